// File: rtl/sev_seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package sev_seg_pkg;
  localparam int N_DIGITS = 4;

  localparam logic [7:0] SEG_DASH       = 8'h0A;
  localparam logic [7:0] SEG_BLANK      = 8'h0B;
  localparam logic [7:0] SEG_UNDERSCORE = 8'h0C;

  localparam logic [6:0] SEGS_OFF = 7'h7F;

  typedef enum logic {ST_ON, ST_BLANK} scan_state_t;
endpackage

// File: rtl/seg_code_decode.sv
// Display code to active-low segment pattern {g,f,e,d,c,b,a}.
module seg_code_decode
  import sev_seg_pkg::*;
(
  input  logic [7:0] code,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEGS_OFF;
    case (code)
      8'h00:          segs = 7'h40;
      8'h01:          segs = 7'h79;
      8'h02:          segs = 7'h24;
      8'h03:          segs = 7'h30;
      8'h04:          segs = 7'h19;
      8'h05:          segs = 7'h12;
      8'h06:          segs = 7'h02;
      8'h07:          segs = 7'h78;
      8'h08:          segs = 7'h00;
      8'h09:          segs = 7'h10;
      SEG_DASH:       segs = 7'h3F;
      SEG_BLANK:      segs = SEGS_OFF;
      SEG_UNDERSCORE: segs = 7'h77;
      default:        segs = SEGS_OFF;
    endcase
  end

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// 4-digit multiplexed seven-segment scanner with a shadowed frame buffer
// that is swapped into the displayed frame only at frame boundaries.
module sev_seg_scan_ctrl
  import sev_seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter int CNT_W     = $clog2(SCAN_DIV)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [31:0] frame_data,
  input  logic [3:0]  dp_mask,
  input  logic        lz_blank_en,
  output logic [3:0]  an,
  output logic [6:0]  a_to_g,
  output logic        dp,
  output logic        frame_done,
  output logic [1:0]  digit_idx
);

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  scan_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0] idx_nxt;
  logic boundary;

  logic [31:0] shadow;
  logic shadow_full;
  logic [N_DIGITS-1:0][7:0] active;
  logic [N_DIGITS-1:0][7:0] eff;
  logic zero_above;
  logic [7:0] cur_code;
  logic [6:0] cur_segs;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;
  logic dp_nxt;
  logic accept;

  // Handshake: a frame moves when frame_valid & frame_ready on a rising clk;
  // frame_ready is high exactly while the shadow is empty, and valid may drop
  // at any time without a transfer.
  assign frame_ready = ~shadow_full;
  assign accept      = frame_valid & ~shadow_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BLANK;
      cnt       <= '0;
      digit_idx <= 2'd3;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      digit_idx <= idx_nxt;
    end
  end

  // Disabled scanning parks at the start of digit 3's blank gap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = digit_idx;
    boundary  = 1'b0;
    if (!en) begin
      state_nxt = ST_BLANK;
      cnt_nxt   = '0;
      idx_nxt   = 2'd3;
    end else if (state == ST_ON) begin
      if (cnt == ON_LAST) begin
        state_nxt = ST_BLANK;
        cnt_nxt   = '0;
      end
    end else if (cnt == BLANK_LAST) begin
      state_nxt = ST_ON;
      cnt_nxt   = '0;
      idx_nxt   = digit_idx + 2'd1;
      boundary  = (digit_idx == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      shadow_full <= 1'b0;
      active      <= {N_DIGITS{SEG_BLANK}};
    end else if (boundary && shadow_full) begin
      active      <= shadow;
      shadow_full <= 1'b0;
    end else if (accept) begin
      shadow      <= frame_data;
      shadow_full <= 1'b1;
    end
  end

  // Leading zeros blank from the leftmost digit down; digit 0 always shows.
  always_comb begin
    eff        = active;
    zero_above = lz_blank_en;
    for (int j = N_DIGITS - 1; j >= 1; j--) begin
      zero_above = zero_above && (active[j] == 8'h00);
      if (zero_above) eff[j] = SEG_BLANK;
    end
  end

  assign cur_code = eff[digit_idx];

  seg_code_decode u_dec (
    .code (cur_code),
    .segs (cur_segs)
  );

  always_comb begin
    an_nxt  = 4'hF;
    seg_nxt = SEGS_OFF;
    dp_nxt  = 1'b1;
    if (en && state == ST_ON) begin
      an_nxt  = ~(4'b0001 << digit_idx);
      seg_nxt = cur_segs;
      dp_nxt  = ~dp_mask[digit_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 4'hF;
      a_to_g     <= SEGS_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      a_to_g     <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Bench for sev_seg_scan_ctrl: a position-in-frame reference model checks every
// cycle, plus table-driven frames and hand-written multi-cycle sequences.
module tb_sev_seg_scan_ctrl;
  localparam int SD     = 8;
  localparam int BC     = 2;
  localparam int ON_CYC = SD - BC;
  localparam int FP     = 4 * SD;
  localparam int PARK   = 3 * SD + ON_CYC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        frame_valid = 1'b0;
  logic [31:0] frame_data = '0;
  logic [3:0]  dp_mask = '0;
  logic        lz_blank_en = 1'b0;
  logic        frame_ready, dp, frame_done;
  logic [3:0]  an;
  logic [6:0]  a_to_g;
  logic [1:0]  digit_idx;

  sev_seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .dp_mask     (dp_mask),
    .lz_blank_en (lz_blank_en),
    .an          (an),
    .a_to_g      (a_to_g),
    .dp          (dp),
    .frame_done  (frame_done),
    .digit_idx   (digit_idx)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [6:0] seg_lut[256];

  // reference model: position within a 4*SD-cycle frame, shadow and shown frame
  int          m_pos;
  logic        m_full;
  logic [31:0] m_shadow;
  logic [7:0]  m_act[4];

  typedef struct {
    logic [31:0] frame;
    logic        lz;
    logic [27:0] segs;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = PARK;
    m_full = 1'b0;
    m_shadow = '0;
    for (int k = 0; k < 4; k++) m_act[k] = 8'h0B;
    exp_q.delete();
  endtask

  function automatic logic [7:0] m_eff(input int k);
    bit z;
    z = 1'b1;
    for (int j = 3; j >= k; j--) if (m_act[j] != 8'h00) z = 1'b0;
    if (lz_blank_en && k > 0 && z) return 8'h0B;
    return m_act[k];
  endfunction

  task automatic model_step();
    int d, w;
    bit bnd, acc, xfr;
    logic [3:0] sel, an_e;
    logic [6:0] seg_e;
    logic dp_e;
    d = m_pos / SD;
    w = m_pos % SD;
    bnd = en && (m_pos == FP - 1);
    an_e = 4'hF;
    seg_e = 7'h7F;
    dp_e = 1'b1;
    if (en && w < ON_CYC) begin
      sel = 4'b0001 << d;
      an_e = ~sel;
      seg_e = seg_lut[m_eff(d)];
      dp_e = ~dp_mask[d];
    end
    acc = frame_valid && !m_full;
    xfr = bnd && m_full;
    if (xfr) begin
      for (int k = 0; k < 4; k++) m_act[k] = m_shadow[8*k +: 8];
      m_full = 1'b0;
    end
    if (acc) begin
      m_shadow = frame_data;
      m_full = 1'b1;
    end
    m_pos = en ? (m_pos + 1) % FP : PARK;
    exp_q.push_back({an_e, seg_e, dp_e, bnd, ~m_full, 2'(m_pos / SD)});
  endtask

  // One clock: model at the edge, compare #1 later, return at the negedge.
  task automatic step();
    logic [15:0] e, a;
    @(posedge clk);
    model_step();
    #1;
    e = exp_q.pop_front();
    a = {an, a_to_g, dp, frame_done, frame_ready, digit_idx};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL cycle_outputs t=%0t actual an=%b seg=%h dp=%b done=%b ready=%b idx=%0d required an=%b seg=%h dp=%b done=%b ready=%b idx=%0d",
               $time, a[15:12], a[11:5], a[4], a[3], a[2], a[1:0],
               e[15:12], e[11:5], e[4], e[3], e[2], e[1:0]);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_an", an, 4'hF);
    check("rst_seg", a_to_g, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_ready", frame_ready, 1'b1);
    check("rst_done", frame_done, 1'b0);
    check("rst_idx", digit_idx, 2'd3);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!frame_done && n < 2 * FP) begin
      step();
      n++;
    end
    check("wait_frame_done", frame_done, 1'b1);
  endtask

  // Captures one full frame starting at digit 0; frame_valid drops after the first cycle.
  task automatic capture_frame(output logic [27:0] segs, output int dp_low, output int dp_bad);
    logic [3:0] sel;
    segs = {4{7'h7F}};
    dp_low = 0;
    dp_bad = 0;
    for (int i = 0; i < FP; i++) begin
      step();
      if (i == 0) frame_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        sel = 4'b0001 << k;
        if (an == ~sel) segs[7*k +: 7] = a_to_g;
      end
      if (dp == 1'b0) begin
        dp_low++;
        if (an != 4'b1011) dp_bad++;
      end
    end
  endtask

  task automatic push_frame(input logic [31:0] data);
    frame_valid = 1'b1;
    frame_data = data;
    step();
    frame_valid = 1'b0;
    frame_data = $urandom;
  endtask

  initial begin
    logic [27:0] got;
    int dlow, dbad, cnt_done, cnt_an0, n;

    for (int c = 0; c < 256; c++) seg_lut[c] = 7'h7F;
    seg_lut[8'h00] = 7'h40; seg_lut[8'h01] = 7'h79; seg_lut[8'h02] = 7'h24;
    seg_lut[8'h03] = 7'h30; seg_lut[8'h04] = 7'h19; seg_lut[8'h05] = 7'h12;
    seg_lut[8'h06] = 7'h02; seg_lut[8'h07] = 7'h78; seg_lut[8'h08] = 7'h00;
    seg_lut[8'h09] = 7'h10; seg_lut[8'h0A] = 7'h3F; seg_lut[8'h0C] = 7'h77;

    vecs[0] = '{32'h0C0A0901, 1'b0, {7'h77, 7'h3F, 7'h10, 7'h79}};
    vecs[1] = '{32'h00000005, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
    vecs[2] = '{32'h00000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{32'h00000005, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12}};
    vecs[4] = '{32'h00050000, 1'b1, {7'h7F, 7'h12, 7'h40, 7'h40}};
    vecs[5] = '{32'h08070605, 1'b0, {7'h00, 7'h78, 7'h02, 7'h12}};
    vecs[6] = '{32'h0D0E0FFF, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    vecs[7] = '{32'h04030201, 1'b1, {7'h19, 7'h30, 7'h24, 7'h79}};

    #2;
    do_reset();

    // free-running scan with no frame loaded
    en = 1'b1;
    cnt_done = 0;
    cnt_an0 = 0;
    for (int i = 0; i < 2 * FP; i++) begin
      step();
      if (frame_done) cnt_done++;
      if (an == 4'b1110) cnt_an0++;
    end
    check("t1_frame_done_count", cnt_done, 2);
    check("t1_digit0_on_cycles", cnt_an0, 2 * ON_CYC);

    // table of frames; the first is pushed immediately after reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      lz_blank_en = vecs[i].lz;
      push_frame(vecs[i].frame);
      check($sformatf("vec%0d_ready_low", i), frame_ready, 1'b0);
      wait_done();
      capture_frame(got, dlow, dbad);
      for (int k = 0; k < 4; k++)
        check($sformatf("vec%0d_digit%0d", i, k), got[7*k +: 7], vecs[i].segs[7*k +: 7]);
    end
    lz_blank_en = 1'b0;

    // A mid-frame, B stalled behind it; no torn frame in between
    n = 0;
    while (digit_idx != 2'd1 && n < 2 * FP) begin
      step();
      n++;
    end
    frame_valid = 1'b1;
    frame_data = 32'h01020304;
    step();
    check("t3_a_accepted", frame_ready, 1'b0);
    frame_data = 32'h09080706;
    step();
    check("t3_b_stalled", frame_ready, 1'b0);
    wait_done();
    capture_frame(got, dlow, dbad);
    check("t3_frame_a", got, {7'h79, 7'h24, 7'h30, 7'h19});
    check("t3_done_after_a", frame_done, 1'b1);
    capture_frame(got, dlow, dbad);
    check("t3_frame_b", got, {7'h10, 7'h00, 7'h78, 7'h02});

    // decimal point on digit 2 only during its on-cycles
    dp_mask = 4'b0100;
    capture_frame(got, dlow, dbad);
    check("t5_dp_low_cycles", dlow, ON_CYC);
    check("t5_dp_outside_digit2", dbad, 0);
    dp_mask = 4'b0000;

    // disable mid-slot, load shadow while parked, then reset mid-frame
    n = 0;
    while (an == 4'hF && n < SD) begin
      step();
      n++;
    end
    en = 1'b0;
    step();
    check("t6_en_off_blank", an, 4'hF);
    check("t6_en_off_idx", digit_idx, 2'd3);
    push_frame(32'h05050505);
    check("t6_shadow_full_while_off", frame_ready, 1'b0);
    repeat (3) step();
    #2;
    do_reset();
    en = 1'b1;
    wait_done();
    capture_frame(got, dlow, dbad);
    check("t6_blank_after_reset", got, {4{7'h7F}});

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 19) != 0);
      frame_valid = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 4; b++)
        frame_data[8*b +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                               ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 12));
      if ($urandom_range(0, 31) == 0) lz_blank_en = ~lz_blank_en;
      if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sev_seg_scan_ctrl.md
Name: sev_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a 4-digit common-anode seven-segment display with active-low anodes and segments. It accepts a 4-digit frame of 8-bit display codes through a valid/ready handshake into a shadow register. It swaps the shadow into the active register only at frame boundaries, so a frame never tears. It cycles the digits with a programmable on-time and an anti-ghosting blank gap. It sits between the decision-tree result logic and the board display pins.

Parameters:
SCAN_DIV, 50000, total clk cycles per digit slot (on + blank); must be > BLANK_CYC.
BLANK_CYC, 16, cycles per slot with all anodes off; must be >= 1.
CNT_W, $clog2(SCAN_DIV), width of the slot counter.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
en  input  1  scan enable; low blanks the display and parks the scanner
frame_valid  input  1  producer has a frame on frame_data
frame_ready  output  1  shadow register empty; frame accepted when valid & ready
frame_data  input  32  digit i code = frame_data[8i+7:8i]; digit 3 is leftmost
dp_mask  input  4  dp_mask[i]=1 lights the decimal point on digit i; sampled live
lz_blank_en  input  1  enables leading-zero blanking on digits 3..1
an  output  4  anode selects, active-low, one-hot-low or all-high
a_to_g  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
frame_done  output  1  one-cycle pulse at each frame boundary
digit_idx  output  2  digit currently in its slot

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: an=4'b1111, a_to_g=7'h7F, dp=1, frame_ready=1, frame_done=0, digit_idx=3.
- Reset values (internal): state=ST_BLANK, slot counter=0, shadow empty, all four active digits = SEG_BLANK (8'h0B).
- State machine ST_ON / ST_BLANK, per digit slot:
  - ST_ON lasts SCAN_DIV-BLANK_CYC cycles, then goes to ST_BLANK.
  - ST_BLANK lasts BLANK_CYC cycles, then digit_idx increments mod 4 and the state goes to ST_ON.
  - Frame period = 4*SCAN_DIV cycles.
- Frame boundary: the last ST_BLANK cycle of digit 3. On that cycle:
  - frame_done pulses.
  - If the shadow is full, active <= shadow and the shadow goes empty.
  - If the shadow is empty, the active frame is retained.
- Handshake:
  - frame_ready = ~shadow_full.
  - Accept = frame_valid & frame_ready; the shadow loads and goes full.
  - Accept and boundary transfer are mutually exclusive by construction. A frame accepted on the boundary cycle waits for the next boundary.
  - frame_data is ignored while ready is low. Valid may drop without being accepted.
- Output latency: outputs are registered, one cycle after the state/index.
  - ST_ON for digit k: an = ~(1<<k), a_to_g = decode(eff_code[k]), dp = ~dp_mask[k].
  - ST_BLANK: an=4'b1111, a_to_g=7'h7F, dp=1.
- Decode table ({g..a}, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
  - 0A=3F dash, 0B=7F blank, 0C=77 underscore
  - any other code = 7F
- Leading-zero blanking: applied combinationally to the active frame.
  - With lz_blank_en=1, digit j (j=3..1) shows SEG_BLANK if its code and all codes above it are 8'h00.
  - Digit 0 is never blanked.
- en=0:
  - Next cycle: outputs take blank values.
  - The scanner parks at ST_BLANK, digit 3, counter 0, with no boundary, no transfer and no frame_done.
  - The handshake still accepts into the shadow.
  - en rising resumes from that parked point; the first boundary occurs BLANK_CYC cycles later.
- First boundary after reset: occurs BLANK_CYC cycles after rst_n deasserts, so a frame accepted at once is displayed immediately.
- Reset mid-operation: all state returns to the reset values and any pending shadow frame is discarded.

Decomposition:
- Package sev_seg_pkg holds:
  - N_DIGITS=4
  - SEG_DASH=8'h0A, SEG_BLANK=8'h0B, SEG_UNDERSCORE=8'h0C
  - SEGS_OFF=7'h7F
  - state enum scan_state_t {ST_ON, ST_BLANK}
- One combinational sub-module, seg_code_decode (8-bit code in, 7-bit active-low segments out), holds the decode table. Instantiate it once on the muxed digit.

Test Plan (SCAN_DIV=8, BLANK_CYC=2):
1. Reset then en=1, no frame -> an toggles 1110/1101/1011/0111 every 8 cycles, each with 6 on-cycles and 2 all-high cycles; a_to_g=7F throughout; frame_done every 32 cycles.
2. Push frame 0x0C0A0901 at t=0 after reset -> from the first boundary, digit0=79, digit1=10, digit2=3F, digit3=77; frame_ready low until that boundary.
3. Push frame A mid-frame, then frame B immediately -> B is stalled (ready=0) until the boundary; the next frame shows A and the frame after shows B; no mixed-digit frame appears.
4. lz_blank_en=1 with frame 0x00000005 -> digits 3..1 = 7F, digit0 = 12. With frame 0x00000000 -> digit0 = 40.
5. dp_mask=4'b0100 -> dp=0 only during digit-2 on-cycles; dp=1 during all blank cycles.
6. Deassert en mid-slot, then assert rst_n low mid-frame with the shadow full -> an=1111 the next cycle. After reset, the shadow is empty, frame_ready=1, and all digits are blank.
